// File: rtl/vga_pixel_feeder.sv
// Pixel FIFO between the processing path and the VGA timing controller; pops one pixel per request and returns it one cycle later.
// Backpressure: oPix_Ready drops when the FIFO is full. Underflow blanks pixels, then drops back to waiting for a fresh SOF.
module vga_pixel_feeder #(
  parameter int AW         = 10,
  parameter int FILL_LEVEL = 512
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iPix_Valid,
  input  logic [23:0]   iPix_Data,
  input  logic          iPix_SOF,
  output logic          oPix_Ready,
  input  logic          iRequest,
  input  logic          iFrameDone,
  output logic [7:0]    oRed,
  output logic [7:0]    oGreen,
  output logic [7:0]    oBlue,
  output logic          oUnderflow,
  output logic [15:0]   oUnderflow_Cnt,
  output logic [AW:0]   oLevel,
  output logic [1:0]    oState
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] FILL_LVL = (AW+1)'(FILL_LEVEL);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    ARMED    = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   mem [DEPTH];
  logic [23:0]   rd_dat;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_nxt;
  logic          frame_err, err_nxt;
  logic          pop_d;
  logic          full, accept, wr_en, pop_req, pop, uf, flush;

  always_comb begin
    full       = (level == FULL_LVL);
    oPix_Ready = !iRST && ((state == WAIT_SOF) || !full);
    accept     = iPix_Valid && oPix_Ready;
    pop_req    = iRequest && (state == STREAM);
    pop        = pop_req && (level != '0);
    uf         = pop_req && (level == '0);
    // The request is resolved before the frame-done decision, so an underflow in this cycle also triggers the flush.
    flush      = (state == STREAM) && iFrameDone && (frame_err || uf);
    wr_en      = accept && ((state != WAIT_SOF) || iPix_SOF) && !flush;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = frame_err || uf;
    level_nxt = level;
    if (wr_en && !pop)
      level_nxt = level + (AW+1)'(1);
    else if (pop && !wr_en)
      level_nxt = level - (AW+1)'(1);
    case (state)
      WAIT_SOF: if (wr_en) state_nxt = FILL;
      FILL:     if (level_nxt >= FILL_LVL) state_nxt = ARMED;
      ARMED:    if (iFrameDone) state_nxt = STREAM;
      STREAM: begin
        if (flush) begin
          state_nxt = WAIT_SOF;
          err_nxt   = 1'b0;
          level_nxt = '0;
        end
      end
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= WAIT_SOF;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      frame_err      <= 1'b0;
      pop_d          <= 1'b0;
      oUnderflow     <= 1'b0;
      oUnderflow_Cnt <= '0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      frame_err  <= err_nxt;
      pop_d      <= pop;
      oUnderflow <= uf;
      if (flush)
        wr_ptr <= '0;
      else if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (flush)
        rd_ptr <= '0;
      else if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (uf && (oUnderflow_Cnt != 16'hFFFF))
        oUnderflow_Cnt <= oUnderflow_Cnt + 16'd1;
    end
  end

  // Memory kept free of reset so it maps onto block RAM; stale read data is masked by pop_d.
  always_ff @(posedge iCLK) begin
    if (wr_en)
      mem[wr_ptr] <= iPix_Data;
    if (pop)
      rd_dat <= mem[rd_ptr];
  end

  assign {oRed, oGreen, oBlue} = pop_d ? rd_dat : 24'd0;
  assign oLevel = level;
  assign oState = state;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: hand-derived vector table plus queue-based reference model for directed and random sequences.
module tb_vga_pixel_feeder;

  localparam int AW    = 10;
  localparam int FILLV = 4;
  localparam int DEPTH = 1 << AW;

  logic          iCLK, iRST, iPix_Valid, iPix_SOF, iRequest, iFrameDone;
  logic [23:0]   iPix_Data;
  logic          oPix_Ready, oUnderflow;
  logic [7:0]    oRed, oGreen, oBlue;
  logic [15:0]   oUnderflow_Cnt;
  logic [AW:0]   oLevel;
  logic [1:0]    oState;

  int checks = 0;
  int errors = 0;

  vga_pixel_feeder #(.AW(AW), .FILL_LEVEL(FILLV)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iPix_Valid(iPix_Valid), .iPix_Data(iPix_Data), .iPix_SOF(iPix_SOF),
    .oPix_Ready(oPix_Ready),
    .iRequest(iRequest), .iFrameDone(iFrameDone),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oUnderflow(oUnderflow), .oUnderflow_Cnt(oUnderflow_Cnt),
    .oLevel(oLevel), .oState(oState)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pixel queue, state number, error flag, saturating count.
  logic [23:0] q[$];
  int          mst;
  bit          merr;
  int          mcnt;
  logic [23:0] mrgb;
  bit          muf;

  task automatic model_reset();
    q.delete();
    mst  = 0;
    merr = 0;
    mcnt = 0;
    mrgb = 24'd0;
    muf  = 0;
  endtask

  task automatic model_step(input logic v, input logic [23:0] d, input logic sof,
                            input logic req, input logic fd);
    bit rdy;
    int ns;
    rdy  = (mst == 0) || (q.size() < DEPTH);
    ns   = mst;
    mrgb = 24'd0;
    muf  = 0;
    if (mst == 3 && req) begin
      if (q.size() > 0) begin
        mrgb = q.pop_front();
      end else begin
        muf  = 1;
        merr = 1;
        if (mcnt < 65535) mcnt++;
      end
    end
    if (v && rdy) begin
      if (mst != 0) q.push_back(d);
      else if (sof) begin
        q.push_back(d);
        ns = 1;
      end
    end
    case (mst)
      1: if (q.size() >= FILLV) ns = 2;
      2: if (fd) ns = 3;
      3: if (fd && merr) begin
           q.delete();
           merr = 0;
           ns   = 0;
         end
      default: ;
    endcase
    mst = ns;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_level"}, 32'(oLevel), 32'(q.size()));
    chk({tag, "_state"}, 32'(oState), 32'(mst));
    chk({tag, "_rgb"}, 32'({oRed, oGreen, oBlue}), 32'(mrgb));
    chk({tag, "_uflow"}, 32'(oUnderflow), 32'(muf));
    chk({tag, "_ucnt"}, 32'(oUnderflow_Cnt), 32'(mcnt));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [23:0] d, input logic sof,
                       input logic req, input logic fd);
    bit exp_rdy;
    iPix_Valid = v; iPix_Data = d; iPix_SOF = sof; iRequest = req; iFrameDone = fd;
    exp_rdy = (mst == 0) || (q.size() < DEPTH);
    #1;
    chk({tag, "_ready"}, 32'(oPix_Ready), 32'(exp_rdy));
    model_step(v, d, sof, req, fd);
    @(posedge iCLK);
    #1;
    check_outputs(tag);
  endtask

  // Requests and valid pixels are driven during reset to show they are ignored.
  task automatic do_reset();
    iRST = 1'b1; iPix_Valid = 1'b1; iPix_Data = 24'hDEADBE; iPix_SOF = 1'b1;
    iRequest = 1'b1; iFrameDone = 1'b1;
    #1;
    chk("rst_ready", 32'(oPix_Ready), 32'd0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0; iPix_Valid = 1'b0; iPix_SOF = 1'b0; iRequest = 1'b0; iFrameDone = 1'b0;
    model_reset();
    chk("rst_level", 32'(oLevel), 32'd0);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
    chk("rst_uflow", 32'(oUnderflow), 32'd0);
    chk("rst_ucnt", 32'(oUnderflow_Cnt), 32'd0);
  endtask

  typedef struct {
    logic        v;
    logic        sof;
    logic        req;
    logic        fd;
    logic [23:0] d;
    int          lvl;
    int          st;
    logic [23:0] rgb;
    logic        uf;
    int          cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    //           v  sof req fd  data         lvl st rgb        uf cnt
    tbl[0]  = '{1, 0, 0, 0, 24'hAAAAAA, 0, 0, 24'h000000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 24'hBBBBBB, 0, 0, 24'h000000, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 24'hCCCCCC, 0, 0, 24'h000000, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 24'h112233, 1, 1, 24'h000000, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 24'h445566, 2, 1, 24'h000000, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 24'h778899, 3, 1, 24'h000000, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 24'hAABBCC, 4, 2, 24'h000000, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 24'h000000, 4, 2, 24'h000000, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 24'h000000, 4, 3, 24'h000000, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 24'h000000, 3, 3, 24'h112233, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 24'h000000, 2, 3, 24'h445566, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 24'h000000, 1, 3, 24'h778899, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 24'h000000, 0, 3, 24'hAABBCC, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 24'h000000, 0, 3, 24'h000000, 1, 1};
    tbl[14] = '{0, 0, 0, 1, 24'h000000, 0, 0, 24'h000000, 0, 1};

    iRST = 1'b1; iPix_Valid = 1'b0; iPix_Data = 24'd0; iPix_SOF = 1'b0;
    iRequest = 1'b0; iFrameDone = 1'b0;
    model_reset();
    @(posedge iCLK);
    #1;
    do_reset();

    // Table: SOF discard, fill, arm, stream, underflow, flush.
    for (int i = 0; i < 15; i++) begin
      iPix_Valid = tbl[i].v; iPix_SOF = tbl[i].sof; iRequest = tbl[i].req;
      iFrameDone = tbl[i].fd; iPix_Data = tbl[i].d;
      @(posedge iCLK);
      #1;
      chk($sformatf("tbl%0d_level", i), 32'(oLevel), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_state", i), 32'(oState), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_rgb", i), 32'({oRed, oGreen, oBlue}), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d_uflow", i), 32'(oUnderflow), 32'(tbl[i].uf));
      chk($sformatf("tbl%0d_ucnt", i), 32'(oUnderflow_Cnt), 32'(tbl[i].cnt));
    end

    // Frame done without error keeps streaming; reset mid-frame clears everything.
    do_reset();
    cycle("mid", 1, 24'h010203, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("mid", 1, 24'h100000 + 24'(i), 0, 0, 0);
    cycle("mid", 0, 24'd0, 0, 0, 1);
    cycle("mid", 0, 24'd0, 0, 1, 0);
    cycle("mid", 0, 24'd0, 0, 1, 0);
    cycle("mid", 0, 24'd0, 0, 0, 1);
    chk("mid_stay_stream", 32'(oState), 32'd3);
    cycle("mid", 0, 24'd0, 0, 1, 0);
    chk("mid_preserved", 32'({oRed, oGreen, oBlue}), 32'h100001);
    cycle("mid", 0, 24'd0, 0, 1, 0);
    do_reset();

    // Fill to capacity, then push against a full FIFO.
    cycle("full", 1, 24'($urandom), 1, 0, 0);
    for (int i = 1; i < DEPTH; i++) cycle("full", 1, 24'($urandom), 0, 0, 0);
    chk("full_level", 32'(oLevel), 32'(DEPTH));
    for (int i = 0; i < 3; i++) cycle("full_blk", 1, 24'($urandom), 0, 0, 0);
    cycle("full", 0, 24'd0, 0, 0, 1);
    cycle("full_pw", 1, 24'h0F0F0F, 0, 1, 0);
    cycle("full_pw", 1, 24'hF0F0F0, 0, 1, 0);
    chk("full_pw_level", 32'(oLevel), 32'(DEPTH - 1));
    cycle("full", 0, 24'd0, 0, 1, 0);
    cycle("full", 0, 24'd0, 0, 0, 0);

    // Random traffic against the model; second half leans toward underflow.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v, s, r, f;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) == 0);
      r = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 49) == 0);
      cycle("rnd", v, 24'($urandom), s, r, f);
    end

    // Saturation of the underflow counter.
    do_reset();
    cycle("sat", 1, 24'h123456, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("sat", 1, 24'h654321, 0, 0, 0);
    cycle("sat", 0, 24'd0, 0, 0, 1);
    for (int i = 0; i < 4 + 65536; i++) cycle("sat", 0, 24'd0, 0, 1, 0);
    chk("sat_cnt", 32'(oUnderflow_Cnt), 32'hFFFF);
    chk("sat_pulse", 32'(oUnderflow), 32'd1);
    cycle("sat", 0, 24'd0, 0, 0, 1);
    chk("sat_flush_state", 32'(oState), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
